stack_unit: RTL and testbench

- Parametrised hardware stack for the 8-bit computer, replacing the stack-pointer/base-pointer pair that the top level has left disabled.
- Holds DEPTH words of DATA_WIDTH in internal storage and maintains SP, the count of stored words.
- Keeps a loadable base pointer BP.
- Provides push, pop and replace-top operations, SP/BP load and drive to the global bus, and full/empty status.
- Detects overflow and underflow and holds them in sticky error flags.

---
 rtl/stack_pkg.sv | 42 ++++
 rtl/stack_mem.sv | 31 +++
 rtl/stack_unit.sv | 158 +++++++++++++++
 tb/tb_stack_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants, operation encoding and control-word layout for the hardware stack.
package stack_pkg;

    localparam int unsigned STK_DATA_WIDTH = 8;
    localparam int unsigned STK_ADDR_BITS  = 4;
    localparam int unsigned STK_DEPTH      = 15;

    // Bit positions of the stack controls inside the control-unit microcode word
    localparam int unsigned CW_PUSH     = 0;
    localparam int unsigned CW_POP      = 1;
    localparam int unsigned CW_SP_IN    = 2;
    localparam int unsigned CW_BP_IN    = 3;
    localparam int unsigned CW_SP_OUT   = 4;
    localparam int unsigned CW_BP_OUT   = 5;
    localparam int unsigned CW_TOP_OUT  = 6;
    localparam int unsigned CW_CLR_ERR  = 7;
    localparam int unsigned CW_WIDTH    = 8;

    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_LOAD    = 3'd1,
        OP_PUSH    = 3'd2,
        OP_POP     = 3'd3,
        OP_REPLACE = 3'd4
    } stk_op_e;

    // SP load outranks push/pop; push with pop is a replace-top
    function automatic stk_op_e decode_op(input logic push, input logic pop, input logic sp_load);
        stk_op_e op;
        op = OP_IDLE;
        if (sp_load)
            op = OP_LOAD;
        else if (push && pop)
            op = OP_REPLACE;
        else if (push)
            op = OP_PUSH;
        else if (pop)
            op = OP_POP;
        return op;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: synchronous write port, combinational read port.
import stack_pkg::*;

module stack_mem #(
    parameter int unsigned DATA_WIDTH = STK_DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = STK_ADDR_BITS,
    parameter int unsigned DEPTH      = STK_DEPTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_c
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Out-of-range addresses are dropped on write and read back as zero
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH))
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_c = '0;
        if (32'(rd_addr) < DEPTH)
            rd_data_c = mem[rd_addr];
    end

endmodule

// File: rtl/stack_unit.sv
// Hardware stack with SP/BP registers, sticky overflow/underflow flags and a one-hot bus driver.
import stack_pkg::*;

module stack_unit #(
    parameter int unsigned DATA_WIDTH = STK_DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = STK_ADDR_BITS,
    parameter int unsigned DEPTH      = STK_DEPTH
) (
    input  logic                  clk,
    input  logic                  RESETn,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  sp_in,
    input  logic                  bp_in,
    input  logic                  sp_out_en,
    input  logic                  bp_out_en,
    input  logic                  top_out_en,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic [ADDR_BITS-1:0]  sp,
    output logic [ADDR_BITS-1:0]  bp,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_BITS-1:0] DEPTH_A = ADDR_BITS'(DEPTH);

    generate
        if ((2 ** ADDR_BITS) < (DEPTH + 1)) begin : g_bad_params
            $error("stack_unit: ADDR_BITS too narrow to hold DEPTH");
        end
    endgenerate

    stk_op_e               op;
    logic [ADDR_BITS-1:0]  load_val;
    logic                  load_ok;
    logic [ADDR_BITS-1:0]  top_addr;
    logic [DATA_WIDTH-1:0] top_data;

    logic [ADDR_BITS-1:0]  sp_nxt;
    logic [ADDR_BITS-1:0]  bp_nxt;
    logic [DATA_WIDTH-1:0] pop_data_nxt;
    logic                  pop_valid_nxt;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;

    assign op       = decode_op(push, pop, sp_in);
    assign load_val = bus_in[ADDR_BITS-1:0];
    assign load_ok  = (load_val <= DEPTH_A);
    assign top_addr = sp - ADDR_BITS'(1);

    stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en     (mem_we),
        .wr_addr   (mem_waddr),
        .wr_data   (bus_in),
        .rd_addr   (top_addr),
        .rd_data_c (top_data)
    );

    // Next-state for SP, pop result, memory write and error events
    always_comb begin
        sp_nxt        = sp;
        bp_nxt        = bp;
        pop_data_nxt  = pop_data;
        pop_valid_nxt = 1'b0;
        ovf_set       = 1'b0;
        unf_set       = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = sp;

        unique case (op)
            OP_LOAD: begin
                if (load_ok)
                    sp_nxt = load_val;
                else
                    ovf_set = 1'b1;
            end
            OP_PUSH: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    sp_nxt = sp + ADDR_BITS'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    pop_data_nxt  = top_data;
                    pop_valid_nxt = 1'b1;
                    sp_nxt        = top_addr;
                end
            end
            OP_REPLACE: begin
                pop_valid_nxt = 1'b1;
                if (empty) begin
                    pop_data_nxt = bus_in;
                end else begin
                    pop_data_nxt = top_data;
                    mem_we       = 1'b1;
                    mem_waddr    = top_addr;
                end
            end
            default: ;
        endcase

        if (bp_in)
            bp_nxt = load_val;
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            sp        <= '0;
            bp        <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            sp        <= sp_nxt;
            bp        <= bp_nxt;
            pop_data  <= pop_data_nxt;
            pop_valid <= pop_valid_nxt;
            // A fresh error wins over a simultaneous clear
            overflow  <= ovf_set | (overflow  & ~clear_err);
            underflow <= unf_set | (underflow & ~clear_err);
            full      <= (sp_nxt == DEPTH_A);
            empty     <= (sp_nxt == '0);
        end
    end

    // Bus driver: exactly one enable selects a source, anything else drives zero
    always_comb begin
        bus_out = '0;
        unique case ({top_out_en, sp_out_en, bp_out_en})
            3'b100:  bus_out = empty ? '0 : top_data;
            3'b010:  bus_out = DATA_WIDTH'(sp);
            3'b001:  bus_out = DATA_WIDTH'(bp);
            default: bus_out = '0;
        endcase
    end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: reference model plus pop-result scoreboard.
`timescale 1ns/1ps

module tb_stack_unit;

    logic       clk = 1'b0;
    logic       RESETn;
    logic [7:0] bus_in;
    logic       push, pop, sp_in, bp_in, sp_out_en, bp_out_en, top_out_en, clear_err;
    logic [7:0] bus_out, pop_data;
    logic       pop_valid, full, empty, overflow, underflow;
    logic [3:0] sp, bp;

    // Wide-SP instance for the illegal-load case
    logic [7:0] b_bus_in;
    logic       b_sp_in, b_clear_err;
    logic [7:0] b_bus_out, b_pop_data;
    logic       b_pop_valid, b_full, b_empty, b_overflow, b_underflow;
    logic [4:0] b_sp, b_bp;

    always #5 clk = ~clk;

    stack_unit dut (
        .clk(clk), .RESETn(RESETn), .bus_in(bus_in), .push(push), .pop(pop),
        .sp_in(sp_in), .bp_in(bp_in), .sp_out_en(sp_out_en), .bp_out_en(bp_out_en),
        .top_out_en(top_out_en), .clear_err(clear_err), .bus_out(bus_out),
        .pop_data(pop_data), .pop_valid(pop_valid), .sp(sp), .bp(bp), .full(full),
        .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    stack_unit #(.DATA_WIDTH(8), .ADDR_BITS(5), .DEPTH(20)) dut_b (
        .clk(clk), .RESETn(RESETn), .bus_in(b_bus_in), .push(1'b0), .pop(1'b0),
        .sp_in(b_sp_in), .bp_in(1'b0), .sp_out_en(1'b0), .bp_out_en(1'b0),
        .top_out_en(1'b0), .clear_err(b_clear_err), .bus_out(b_bus_out),
        .pop_data(b_pop_data), .pop_valid(b_pop_valid), .sp(b_sp), .bp(b_bp),
        .full(b_full), .empty(b_empty), .overflow(b_overflow), .underflow(b_underflow)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model
    int         m_sp, m_bp;
    bit         m_ovf, m_unf;
    logic [7:0] m_pd;
    logic [7:0] m_mem [16];
    bit         m_vld [16];
    logic [8:0] sb_q [$];   // bit 8 = value is known

    always @(negedge clk)
        assert ($countones({top_out_en, sp_out_en, bp_out_en}) <= 1)
            else $error("more than one bus out-enable active");

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sp = 0; m_bp = 0; m_ovf = 0; m_unf = 0; m_pd = 8'h00;
        for (int i = 0; i < 16; i++) m_vld[i] = 0;
        sb_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".sp"},    32'(sp),        32'(m_sp));
        chk({tag, ".bp"},    32'(bp),        32'(m_bp));
        chk({tag, ".full"},  32'(full),      32'(m_sp == 15));
        chk({tag, ".empty"}, 32'(empty),     32'(m_sp == 0));
        chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
        chk({tag, ".unf"},   32'(underflow), 32'(m_unf));
        chk({tag, ".pd"},    32'(pop_data),  32'(m_pd));
        chk({tag, ".idle"},  32'(bus_out),   32'h0);
        top_out_en = 1'b1;
        #1;
        if (m_sp == 0)
            chk({tag, ".top0"}, 32'(bus_out), 32'h0);
        else if (m_vld[m_sp-1])
            chk({tag, ".top"}, 32'(bus_out), 32'(m_mem[m_sp-1]));
        top_out_en = 1'b0;
    endtask

    // One clock of stimulus; model advances, pop results go through the scoreboard
    task automatic op(input string tag, input bit pu, input bit po, input bit spi,
                      input bit bpi, input bit clr, input logic [7:0] d);
        bit exp_pv, o_set, u_set;
        logic [8:0] sb;
        exp_pv = 0; o_set = 0; u_set = 0;
        @(negedge clk);
        push = pu; pop = po; sp_in = spi; bp_in = bpi; clear_err = clr; bus_in = d;
        if (spi) begin
            if (int'(d[3:0]) <= 15) m_sp = int'(d[3:0]); else o_set = 1;
        end else if (pu && po) begin
            exp_pv = 1;
            if (m_sp == 0) begin
                sb_q.push_back({1'b1, d});
            end else begin
                sb_q.push_back({1'(m_vld[m_sp-1]), m_mem[m_sp-1]});
                m_mem[m_sp-1] = d; m_vld[m_sp-1] = 1;
            end
        end else if (pu) begin
            if (m_sp == 15) o_set = 1;
            else begin m_mem[m_sp] = d; m_vld[m_sp] = 1; m_sp++; end
        end else if (po) begin
            if (m_sp == 0) u_set = 1;
            else begin
                exp_pv = 1;
                sb_q.push_back({1'(m_vld[m_sp-1]), m_mem[m_sp-1]});
                m_sp--;
            end
        end
        if (bpi) m_bp = int'(d[3:0]);
        m_ovf = o_set | (m_ovf & !clr);
        m_unf = u_set | (m_unf & !clr);
        @(posedge clk);
        #1;
        push = 0; pop = 0; sp_in = 0; bp_in = 0; clear_err = 0;
        chk({tag, ".pv"}, 32'(pop_valid), 32'(exp_pv));
        if (pop_valid) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".orphan_pv"}, 32'(pop_valid), 32'h0);
            end else begin
                sb = sb_q.pop_front();
                m_pd = pop_data;
                if (sb[8]) begin
                    m_pd = sb[7:0];
                    chk({tag, ".sb"}, 32'(pop_data), 32'(sb[7:0]));
                end
            end
        end
        check_state(tag);
    endtask

    task automatic bus_chk(input string tag, input bit s, input bit b, input logic [7:0] exp);
        @(negedge clk);
        sp_out_en = s; bp_out_en = b;
        #1;
        chk(tag, 32'(bus_out), 32'(exp));
        sp_out_en = 0; bp_out_en = 0;
    endtask

    initial begin
        RESETn = 1'b0;
        bus_in = '0; push = 0; pop = 0; sp_in = 0; bp_in = 0;
        sp_out_en = 0; bp_out_en = 0; top_out_en = 0; clear_err = 0;
        b_bus_in = '0; b_sp_in = 0; b_clear_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset.pv", 32'(pop_valid), 32'h0);
        @(negedge clk);
        RESETn = 1'b1;

        // Basic push/pop
        op("push11", 1, 0, 0, 0, 0, 8'h11);
        op("push22", 1, 0, 0, 0, 0, 8'h22);
        op("push33", 1, 0, 0, 0, 0, 8'h33);
        op("pop33",  0, 1, 0, 0, 0, 8'h00);
        op("pop22",  0, 1, 0, 0, 0, 8'h00);
        op("pop11",  0, 1, 0, 0, 0, 8'h00);
        op("idle",   0, 0, 0, 0, 0, 8'h00);

        // Fill, overflow, clear
        for (int i = 1; i <= 15; i++) op("fill", 1, 0, 0, 0, 0, 8'(i));
        op("push_full", 1, 0, 0, 0, 0, 8'hAA);
        op("clr_ovf",   0, 0, 0, 0, 1, 8'h00);
        op("repl_full", 1, 1, 0, 0, 0, 8'hC3);

        // Underflow, set-wins-over-clear
        op("sp_ld0",    0, 0, 1, 0, 0, 8'h00);
        op("pop_empty", 0, 1, 0, 0, 0, 8'h00);
        op("pop_clr",   0, 1, 0, 0, 1, 8'h00);
        op("clr_unf",   0, 0, 0, 0, 1, 8'h00);

        // Replace top and empty pass-through
        op("push11b",  1, 0, 0, 0, 0, 8'h11);
        op("push22b",  1, 0, 0, 0, 0, 8'h22);
        op("repl99",   1, 1, 0, 0, 0, 8'h99);
        op("pop99",    0, 1, 0, 0, 0, 8'h00);
        op("sp_ld0b",  0, 0, 1, 0, 0, 8'h00);
        op("pass5a",   1, 1, 0, 0, 0, 8'h5A);

        // SP loads
        op("sp_ld5",    0, 0, 1, 0, 0, 8'h05);
        op("sp_ld15",   0, 0, 1, 0, 0, 8'h0F);
        op("sp_ld10",   0, 0, 1, 0, 0, 8'h10);
        op("sp_ld3_pu", 1, 0, 1, 0, 0, 8'h03);
        op("sp_ld2_po", 0, 1, 1, 0, 0, 8'h02);

        // BP and bus drive
        op("bp_ld7", 0, 0, 0, 1, 0, 8'h07);
        bus_chk("bus_bp", 0, 1, 8'h07);
        bus_chk("bus_sp", 1, 0, 8'(m_sp));
        op("bp_push", 1, 0, 0, 1, 0, 8'h6C);

        // Randomised traffic
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [7:0] d;
            r = int'($urandom_range(0, 9));
            d = 8'($urandom);
            case (r)
                0, 1, 2, 3: op("rnd_push", 1, 0, 0, 0, 0, d);
                4, 5, 6:    op("rnd_pop",  0, 1, 0, 0, 0, d);
                7:          op("rnd_repl", 1, 1, 0, 0, 0, d);
                8:          op("rnd_clr",  0, 0, 0, 0, 1, d);
                default:    op("rnd_bp",   0, 0, 0, 1, 0, d);
            endcase
        end

        // Wide instance: illegal and legal SP loads
        @(negedge clk);
        b_bus_in = 8'd25; b_sp_in = 1;
        @(posedge clk); #1;
        b_sp_in = 0;
        chk("b_ld25.sp",  32'(b_sp),       32'd0);
        chk("b_ld25.ovf", 32'(b_overflow), 32'd1);
        @(negedge clk);
        b_bus_in = 8'd20; b_sp_in = 1; b_clear_err = 1;
        @(posedge clk); #1;
        b_sp_in = 0; b_clear_err = 0;
        chk("b_ld20.sp",   32'(b_sp),       32'd20);
        chk("b_ld20.full", 32'(b_full),     32'd1);
        chk("b_ld20.ovf",  32'(b_overflow), 32'd0);

        // Reset pulse in the middle of a push
        op("pre_rst", 1, 0, 0, 1, 0, 8'h04);
        @(negedge clk);
        push = 1; bus_in = 8'h77;
        #2;
        RESETn = 1'b0;
        #1;
        chk("rst_mid.sp",    32'(sp),    32'd0);
        chk("rst_mid.bp",    32'(bp),    32'd0);
        chk("rst_mid.empty", 32'(empty), 32'd1);
        @(negedge clk);
        push = 0;
        RESETn = 1'b1;
        model_reset();
        check_state("post_rst");
        op("post_rst_push", 1, 0, 0, 0, 0, 8'h3C);
        op("post_rst_pop",  0, 1, 0, 0, 0, 8'h00);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
